mult_share_arbiter: RTL and testbench

//  Shares one shift-add multiplier among NREQ requesters. Arbitration is round-robin.

---
 rtl/mult_share_arbiter.sv | 136 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one multiplier among NREQ clients:
// grant, latch operands, pulse start, wait for done (with watchdog), ack winner.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  output logic [NREQ-1:0]         ack,
  output logic [2*WIDTH:0]        result,
  output logic                    err,
  output logic                    busy,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH:0]        mul_product,
  input  logic                    mul_done
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [IDW-1:0]    ptr_q, gid_q;
  logic [WDW-1:0]    wdog_q;
  logic [NREQ-1:0]   ack_q;
  logic [2*WIDTH:0]  result_q;
  logic              err_q, busy_q, mul_start_q;
  logic [WIDTH-1:0]  mul_a_q, mul_b_q;

  logic [IDW-1:0]    win_d, ptr_d;
  logic              found_d;
  logic [NREQ-1:0]   ack_d;
  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];
  int                idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = op_a[i*WIDTH +: WIDTH];
      b_arr[i] = op_b[i*WIDTH +: WIDTH];
    end
  end

  // First requester at or after ptr, wrapping, wins.
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found_d && req[IDW'(idx)]) begin
        found_d = 1'b1;
        win_d   = IDW'(idx);
      end
    end
  end

  always_comb begin
    ack_d = {{(NREQ-1){1'b0}}, 1'b1} << gid_q;
    ptr_d = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      wdog_q      <= '0;
      ack_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            gid_q       <= win_d;
            mul_a_q     <= a_arr[win_d];
            mul_b_q     <= b_arr[win_d];
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_start_q <= 1'b0;
          wdog_q      <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // A done seen during ISSUE belongs to a previous op and is ignored.
          if (mul_done) begin
            result_q <= mul_product;
            err_q    <= 1'b0;
            ack_q    <= ack_d;
            state_q  <= S_RESP;
          end else if (wdog_q == WDW'(TIMEOUT)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            ack_q    <= ack_d;
            state_q  <= S_RESP;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        S_RESP: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier of
// programmable latency and a queue of expected acks.
module tb_mult_share_arbiter;
  localparam int NREQ = 4, WIDTH = 4, TIMEOUT = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [15:0] op_a, op_b;
  logic [3:0]  ack;
  logic [8:0]  result;
  logic        err, busy, mul_start;
  logic [3:0]  mul_a, mul_b;
  logic [8:0]  mul_product;
  logic        mul_done;

  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  // Multiplier stand-in: done pulses lat cycles after start is seen (never if tie0).
  int   lat;
  logic tie0;
  int   cnt;
  always @(posedge clk) begin
    if (!rst) begin
      cnt <= 0; mul_done <= 1'b0; mul_product <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_start && !tie0) begin
        mul_product <= {5'd0, mul_a} * {5'd0, mul_b};
        if (lat == 0) mul_done <= 1'b1;
        else cnt <= lat;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) mul_done <= 1'b1;
      end
    end
  end

  typedef struct { int id; logic [8:0] res; logic err; } exp_t;
  exp_t sb[$];
  int npass = 0, ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, expv);
  endtask

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
    op_a[id*4 +: 4] = a;
    op_b[id*4 +: 4] = b;
    req[id] = 1'b1;
  endtask

  task automatic push(input int id, input logic [3:0] a, input logic [3:0] b, input logic e_err);
    exp_t e;
    e.id  = id;
    e.res = e_err ? 9'd0 : {5'd0, a} * {5'd0, b};
    e.err = e_err;
    sb.push_back(e);
  endtask

  // Wait for the next ack, checking it against the head of the queue and the
  // expected start-to-ack distance (multiplier latency + 2).
  task automatic expect_ack(input string tag, input int budget, input int exp_lat, input bit chg);
    exp_t e;
    int s, a, n;
    s = -1; a = -1; n = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (mul_start) begin
        n++; s = c;
        if (chg) op_a[3:0] = 4'hF;
      end
      if (|ack) begin a = c; break; end
    end
    e = sb.pop_front();
    chk({tag, " ack"},     32'(ack),    32'(4'b0001 << e.id));
    chk({tag, " result"},  32'(result), 32'(e.res));
    chk({tag, " err"},     32'(err),    32'(e.err));
    chk({tag, " busy"},    32'(busy),   32'd1);
    chk({tag, " starts"},  32'(n),      32'd1);
    chk({tag, " latency"}, 32'(a - s),  32'(exp_lat + 2));
  endtask

  initial begin
    int started;
    rst = 1'b0; req = '0; op_a = '0; op_b = '0; lat = 5; tie0 = 1'b0;

    // 1. reset
    repeat (2) @(negedge clk);
    chk("rst ack",       32'(ack),       32'd0);
    chk("rst result",    32'(result),    32'd0);
    chk("rst err",       32'(err),       32'd0);
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst mul_start", 32'(mul_start), 32'd0);
    chk("rst mul_a",     32'(mul_a),     32'd0);
    chk("rst mul_b",     32'(mul_b),     32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle busy",  32'(busy),      32'd0);
    chk("idle start", 32'(mul_start), 32'd0);

    // 2. single request 13 x 11
    lat = 5;
    set_req(1, 4'd13, 4'd11); push(1, 4'd13, 4'd11, 1'b0);
    expect_ack("t2", 40, 5, 1'b0);
    req[1] = 1'b0;
    @(negedge clk);
    chk("t2 ack clr",  32'(ack),   32'd0);
    chk("t2 err clr",  32'(err),   32'd0);
    chk("t2 busy clr", 32'(busy),  32'd0);
    chk("t2 mul_a",    32'(mul_a), 32'd13);

    // 3. all four held from ptr=0: order 0,1,2,3,0
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    set_req(0, 4'd3, 4'd5); set_req(1, 4'd7, 4'd2);
    set_req(2, 4'd15, 4'd14); set_req(3, 4'd9, 4'd9);
    push(0, 4'd3, 4'd5, 1'b0); push(1, 4'd7, 4'd2, 1'b0);
    push(2, 4'd15, 4'd14, 1'b0); push(3, 4'd9, 4'd9, 1'b0);
    push(0, 4'd3, 4'd5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      lat = k;
      expect_ack("t3", 40, k, 1'b0);
    end
    req = '0;

    // 4. watchdog abort, then a normal op
    tie0 = 1'b1;
    set_req(1, 4'd5, 4'd6); push(1, 4'd5, 4'd6, 1'b1);
    expect_ack("t4 abort", 80, TIMEOUT, 1'b0);
    req[1] = 1'b0;
    tie0 = 1'b0; lat = 3;
    set_req(2, 4'd2, 4'd3); push(2, 4'd2, 4'd3, 1'b0);
    expect_ack("t4 next", 40, 3, 1'b0);
    req[2] = 1'b0;

    // 5. reset during WAIT (ptr is 3 beforehand)
    lat = 20;
    set_req(1, 4'd4, 4'd4);
    started = 0;
    for (int c = 0; c < 10 && started == 0; c++) begin
      @(negedge clk);
      if (mul_start) started = 1;
    end
    chk("t5 started", 32'(started), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0; req = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5 rst ack",  32'(ack),  32'd0);
      chk("t5 rst busy", 32'(busy), 32'd0);
    end
    rst = 1'b1; lat = 4;
    set_req(0, 4'd6, 4'd7); set_req(2, 4'd10, 4'd12); set_req(3, 4'd1, 4'd8);
    push(0, 4'd6, 4'd7, 1'b0); push(2, 4'd10, 4'd12, 1'b0); push(3, 4'd1, 4'd8, 1'b0);
    expect_ack("t5 r0", 40, 4, 1'b0); req[0] = 1'b0;
    expect_ack("t5 r2", 40, 4, 1'b0); req[2] = 1'b0;
    expect_ack("t5 r3", 40, 4, 1'b0); req[3] = 1'b0;

    // 6. operand change after grant; max product
    lat = 6;
    set_req(0, 4'd7, 4'd9); push(0, 4'd7, 4'd9, 1'b0);
    expect_ack("t6 r0", 40, 6, 1'b1);
    req[0] = 1'b0;
    chk("t6 mul_a held", 32'(mul_a), 32'd7);
    set_req(3, 4'd15, 4'd15); push(3, 4'd15, 4'd15, 1'b0);
    expect_ack("t6 max", 40, 6, 1'b0);
    req[3] = 1'b0;
    chk("t6 mul_a", 32'(mul_a), 32'd15);
    chk("t6 mul_b", 32'(mul_b), 32'd15);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
